quad_step_decoder: RTL and testbench

Quadrature front end that turns asynchronous encoder phase inputs A/B and an index input I into single-cycle step pulses, a direction level and an index "zero" pulse. Its outputs drive the `carry`, `dir` and `zero` inputs of the team's 16-bit up/down position counter: one step pulse per valid quadrature edge (x4 decoding). It synchronises and glitch-filters the inputs, tracks the Gray-code phase, and flags illegal phase jumps.

---
 rtl/quad_step_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder.
// Turns asynchronous encoder phases A/B and index I into registered step, direction
// and zero pulses for a 16-bit up/down position counter, using x4 decoding.
// Also flags illegal quadrature jumps with a sticky error bit.
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       idx_in,
    input  logic       en,
    input  logic       err_clr,
    output logic       step,
    output logic       dir,
    output logic       zero,
    output logic       err,
    output logic [1:0] phase
);

    // Channel ordering used throughout: [2] = index, [1] = A, [0] = B.
    localparam int unsigned CH_IDX = 2;

    localparam logic [3:0] FILT_LIMIT   = 4'(FILT_LEN);
    localparam logic [4:0] SETTLE_LIMIT = 5'(FILT_LEN + 2);

    logic [2:0]      rawIn;
    logic [2:0]      meta_q;
    logic [2:0]      sync_q;
    logic [2:0]      filt_q;
    logic [2:0]      filt_d;
    logic [2:0][3:0] runCnt_q;
    logic [2:0][3:0] runCnt_d;

    logic [4:0]      settleCnt_q;
    logic [4:0]      settleCnt_d;
    logic            settling;

    logic [1:0]      prevPhase_q;
    logic            prevIdx_q;

    logic            step_q;
    logic            step_d;
    logic            dir_q;
    logic            dir_d;
    logic            zero_q;
    logic            zero_d;
    logic            err_q;
    logic            err_d;

    logic [1:0]      curPos;
    logic [1:0]      prevPos;
    logic [1:0]      posFwd;
    logic [1:0]      posRev;
    logic [1:0]      posJump;
    logic            isFwd;
    logic            isRev;
    logic            isIllegal;
    logic            idxRise;
    logic            atZeroPhase;

    assign rawIn = {idx_in, a_in, b_in};

    // Position of a phase along the forward Gray sequence 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] grayPos(input logic [1:0] ab);
        logic [1:0] pos;
        unique case (ab)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // Two-flop synchroniser for all three asynchronous encoder inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= rawIn;
            sync_q <= meta_q;
        end
    end

    // Settle window after reset: lets the filters pick up the resting encoder
    // position without it being mistaken for motion.
    assign settling = (settleCnt_q < SETTLE_LIMIT);

    always_comb begin
        settleCnt_d = settleCnt_q;
        if (settling) begin
            settleCnt_d = settleCnt_q + 5'd1;
        end
    end

    // Settle counter register; restarts on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            settleCnt_q <= '0;
        end else begin
            settleCnt_q <= settleCnt_d;
        end
    end

    // Glitch filter: a channel's filtered value follows only after the synced
    // value has disagreed with it for FILT_LEN consecutive cycles.
    always_comb begin
        filt_d   = filt_q;
        runCnt_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (settling) begin
                filt_d[ch] = sync_q[ch];
            end else if (sync_q[ch] != filt_q[ch]) begin
                if (runCnt_q[ch] + 4'd1 == FILT_LIMIT) begin
                    filt_d[ch] = sync_q[ch];
                end else begin
                    runCnt_d[ch] = runCnt_q[ch] + 4'd1;
                end
            end
        end
    end

    // Filtered values and run counters; reset discards any pending run.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= '0;
            runCnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            runCnt_q <= runCnt_d;
        end
    end

    // Classify the move from the previous phase to the current filtered phase.
    always_comb begin
        curPos      = grayPos(filt_q[1:0]);
        prevPos     = grayPos(prevPhase_q);
        posFwd      = prevPos + 2'd1;
        posRev      = prevPos - 2'd1;
        posJump     = prevPos + 2'd2;
        isFwd       = (curPos == posFwd);
        isRev       = (curPos == posRev);
        isIllegal   = (curPos == posJump);
        idxRise     = filt_q[CH_IDX] & ~prevIdx_q;
        atZeroPhase = (filt_q[1:0] == 2'b00);
    end

    // Output next-state: pulses are gated by en, while direction and the error
    // flag keep tracking so the counter stays coherent when re-enabled.
    // Nothing but err_clr acts during settle, including direction, so the
    // resting position never looks like a move.
    always_comb begin
        step_d = 1'b0;
        zero_d = 1'b0;
        dir_d  = dir_q;
        err_d  = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (!settling) begin
            if (isFwd) begin
                step_d = en;
                dir_d  = 1'b0;
            end else if (isRev) begin
                step_d = en;
                dir_d  = 1'b1;
            end
            if (isIllegal) begin
                err_d = 1'b1;
            end
            zero_d = en & idxRise & atZeroPhase;
        end
    end

    // Phase history and registered outputs; the phase state always adopts the
    // current filtered value, even after an illegal jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            prevPhase_q <= 2'b00;
            prevIdx_q   <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prevPhase_q <= filt_q[1:0];
            prevIdx_q   <= filt_q[CH_IDX];
            step_q      <= step_d;
            dir_q       <= dir_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign zero  = zero_q;
    assign err   = err_q;
    assign phase = filt_q[1:0];

endmodule

// File: tb/tb_quad_step_decoder.sv
// Testbench for quad_step_decoder with FILT_LEN = 4.
// Table of held input levels with expected step/zero counts and final levels,
// plus directed sequences for reset settle, latency, glitches and errors.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       aIn;
    logic       bIn;
    logic       idxIn;
    logic       en;
    logic       errClr;
    logic       step;
    logic       dir;
    logic       zero;
    logic       err;
    logic [1:0] phase;

    int compared = 0;
    int mismatched = 0;

    int   stepCnt;
    int   zeroCnt;
    logic firstDir;
    int   backToBack;
    int   nonZeroPhase;
    logic lastStep;

    typedef struct {
        logic       a;
        logic       b;
        logic       idx;
        logic       en;
        int         expSteps;
        int         expZero;
        logic       expDir;
        logic [1:0] expPhase;
    } vec_t;

    vec_t vecs[20];

    quad_step_decoder #(.FILT_LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (aIn),
        .b_in    (bIn),
        .idx_in  (idxIn),
        .en      (en),
        .err_clr (errClr),
        .step    (step),
        .dir     (dir),
        .zero    (zero),
        .err     (err),
        .phase   (phase)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Advance one cycle and land 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        stepCnt      = 0;
        zeroCnt      = 0;
        firstDir     = 1'b0;
        backToBack   = 0;
        nonZeroPhase = 0;
        lastStep     = 1'b0;
    endtask

    // Run n cycles while tallying output pulses.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (step === 1'b1) begin
                if (stepCnt == 0) firstDir = dir;
                stepCnt++;
                if (lastStep) backToBack++;
            end
            lastStep = (step === 1'b1);
            if (zero === 1'b1) zeroCnt++;
            if (phase !== 2'b00) nonZeroPhase++;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        // {a, b, idx, en, steps, zeros, dir, phase}, each held for 10 cycles from phase 00
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 2'b01};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 2'b11};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 2'b10};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 2'b00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 2'b10};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 2'b11};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 2'b01};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 2'b01};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 2'b00};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1, 2'b00};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 2'b00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 2'b01};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 2'b01};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 2'b00};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 2'b00};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'b01};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'b11};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 2'b10};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 2'b00};

        rst    = 1'b1;
        aIn    = 1'b1;
        bIn    = 1'b1;
        idxIn  = 1'b0;
        en     = 1'b1;
        errClr = 1'b0;
        clearMon();

        // Reset with the encoder resting at 11
        repeat (3) tick();
        checkOutput("reset step", step, 0);
        checkOutput("reset dir", dir, 0);
        checkOutput("reset zero", zero, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset phase", phase, 0);
        rst = 1'b0;
        clearMon();
        applyStimulus(6);
        checkOutput("settle steps", stepCnt, 0);
        checkOutput("settle err", err, 0);
        checkOutput("settle phase", phase, 3);
        clearMon();
        applyStimulus(10);
        checkOutput("post-settle steps", stepCnt, 0);
        checkOutput("post-settle err", err, 0);
        checkOutput("post-settle phase", phase, 3);

        // Restart from rest at 00
        rst = 1'b1;
        aIn = 1'b0;
        bIn = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        clearMon();
        applyStimulus(12);
        checkOutput("rest00 phase", phase, 0);
        checkOutput("rest00 steps", stepCnt, 0);

        // Input edge to step pulse latency: 7 cycles
        bIn = 1'b1;
        repeat (6) tick();
        checkOutput("latency cycle6 step", step, 0);
        tick();
        checkOutput("latency cycle7 step", step, 1);
        checkOutput("latency cycle7 dir", dir, 0);
        tick();
        checkOutput("latency cycle8 step", step, 0);
        applyStimulus(4);
        bIn = 1'b0;
        clearMon();
        applyStimulus(10);
        checkOutput("latency return steps", stepCnt, 1);
        checkOutput("latency return dir", dir, 1);

        // Table of held levels
        for (int v = 0; v < 20; v++) begin
            aIn   = vecs[v].a;
            bIn   = vecs[v].b;
            idxIn = vecs[v].idx;
            en    = vecs[v].en;
            clearMon();
            applyStimulus(10);
            checkOutput($sformatf("vec%0d steps", v), stepCnt, vecs[v].expSteps);
            checkOutput($sformatf("vec%0d zeros", v), zeroCnt, vecs[v].expZero);
            checkOutput($sformatf("vec%0d dir", v), dir, vecs[v].expDir);
            checkOutput($sformatf("vec%0d phase", v), phase, vecs[v].expPhase);
            checkOutput($sformatf("vec%0d err", v), err, 0);
            checkOutput($sformatf("vec%0d back-to-back", v), backToBack, 0);
        end

        // 3-cycle glitch on A is rejected
        clearMon();
        aIn = 1'b1;
        applyStimulus(3);
        aIn = 1'b0;
        applyStimulus(15);
        checkOutput("glitch3 steps", stepCnt, 0);
        checkOutput("glitch3 phase excursions", nonZeroPhase, 0);

        // 4-cycle glitch passes: reverse to 10, then forward back to 00
        clearMon();
        aIn = 1'b1;
        applyStimulus(4);
        aIn = 1'b0;
        applyStimulus(15);
        checkOutput("glitch4 steps", stepCnt, 2);
        checkOutput("glitch4 first dir", firstDir, 1);
        checkOutput("glitch4 final dir", dir, 0);
        checkOutput("glitch4 phase", phase, 0);
        checkOutput("glitch4 back-to-back", backToBack, 0);

        // Illegal 00 -> 11 jump
        clearMon();
        aIn = 1'b1;
        bIn = 1'b1;
        applyStimulus(12);
        checkOutput("jump steps", stepCnt, 0);
        checkOutput("jump err", err, 1);
        checkOutput("jump phase", phase, 3);
        checkOutput("jump dir held", dir, 0);

        // err_clr clears the sticky flag
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        tick();
        checkOutput("err_clr err", err, 0);

        // err_clr coincident with a second illegal jump: set wins
        clearMon();
        aIn = 1'b0;
        bIn = 1'b0;
        applyStimulus(6);
        checkOutput("jump2 pre err", err, 0);
        errClr = 1'b1;
        applyStimulus(1);
        errClr = 1'b0;
        checkOutput("jump2 set-wins err", err, 1);
        applyStimulus(5);
        checkOutput("jump2 held err", err, 1);
        checkOutput("jump2 steps", stepCnt, 0);
        checkOutput("jump2 phase", phase, 0);

        // Mid-operation reset clears sticky state
        aIn = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset err", err, 0);
        checkOutput("midreset phase", phase, 0);
        checkOutput("midreset step", step, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
